// File: rtl/reaction_ctrl.sv
// Reaction-time tester: random wait after start, then lights the lamp and
// measures the time to stop in milliseconds, flagging early presses and timeouts.
module reaction_ctrl #(
  parameter int TICKS_PER_MS = 100000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int TIMEOUT_MS   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic        led,
  output logic [13:0] ms_count,
  output logic        busy,
  output logic        done,
  output logic        early,
  output logic        timeout
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REACT, S_DONE} state_t;

  state_t        r_state, w_state;
  logic [15:0]   r_lfsr;
  logic [PW-1:0] r_presc, w_presc;
  logic [12:0]   r_delay, w_delay;
  logic [13:0]   r_ms, w_ms;
  logic          r_led, r_busy, r_done, r_early, r_timeout;
  logic          w_early, w_timeout;
  logic          w_tick, w_fb;

  assign w_tick = (r_presc == PW'(TICKS_PER_MS - 1));
  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    w_state   = r_state;
    w_delay   = r_delay;
    w_ms      = r_ms;
    w_early   = r_early;
    w_timeout = r_timeout;
    w_presc   = w_tick ? '0 : r_presc + PW'(1);
    case (r_state)
      S_IDLE, S_DONE: begin
        // start has priority over a coincident stop here
        if (start) begin
          w_state   = S_WAIT;
          w_delay   = 13'(MIN_DELAY_MS) + 13'(r_lfsr[11:0]);
          w_ms      = '0;
          w_early   = 1'b0;
          w_timeout = 1'b0;
          w_presc   = '0;
        end
      end
      S_WAIT: begin
        if (stop) begin
          w_state = S_DONE;
          w_early = 1'b1;
          w_ms    = 14'd9999;
        end else if (w_tick) begin
          if (r_delay <= 13'd1) begin
            w_state = S_REACT;
            w_delay = '0;
            w_ms    = '0;
            w_presc = '0;
          end else begin
            w_delay = r_delay - 13'd1;
          end
        end
      end
      S_REACT: begin
        // stop freezes the count even when it lands on a tick
        if (stop) begin
          w_state = S_DONE;
        end else if (w_tick) begin
          if (r_ms == 14'(TIMEOUT_MS - 1)) begin
            w_state   = S_DONE;
            w_timeout = 1'b1;
          end
          w_ms = r_ms + 14'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= 16'hACE1;
      r_presc   <= '0;
      r_delay   <= '0;
      r_ms      <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_early   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_lfsr    <= {r_lfsr[14:0], w_fb};
      r_presc   <= w_presc;
      r_delay   <= w_delay;
      r_ms      <= w_ms;
      r_led     <= (w_state == S_REACT);
      r_busy    <= (w_state == S_WAIT) || (w_state == S_REACT);
      r_done    <= (w_state == S_DONE);
      r_early   <= w_early;
      r_timeout <= w_timeout;
    end
  end

  assign led      = r_led;
  assign ms_count = r_ms;
  assign busy     = r_busy;
  assign done     = r_done;
  assign early    = r_early;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Randomized bench for reaction_ctrl: trial outcomes are predicted from the
// stop-press offset and an LFSR-derived delay.
module tb_reaction_ctrl;
  localparam int T = 4, MIN = 20, TO = 50;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic led, busy, done, early, timeout;
  logic [13:0] ms_count;

  int checks = 0, failures = 0;
  int exp_d;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  reaction_ctrl #(.TICKS_PER_MS(T), .MIN_DELAY_MS(MIN), .TIMEOUT_MS(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .led(led),
    .ms_count(ms_count), .busy(busy), .done(done), .early(early), .timeout(timeout)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_result(input string tag, input int ms, input bit e, input bit t);
    chk({tag, "_ms"}, 32'(ms_count), 32'(ms));
    chk({tag, "_early"}, 32'(early), 32'(e));
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_led"}, 32'(led), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Start is sampled at the next edge using the LFSR value held before it.
  task automatic do_start(input bit with_stop);
    exp_d = (MIN + int'(m_lfsr[11:0])) * T;
    start = 1'b1; stop = with_stop;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ms_clr", 32'(ms_count), 0);
    chk("start_flags_clr", 32'({early, timeout, done, led}), 0);
  endtask

  // Idle a random while, then until the delay would be short, to bound run time.
  task automatic idle_short();
    int k;
    k = $urandom_range(0, 30);
    repeat (k) step();
    k = 0;
    while (m_lfsr[11:0] >= 12'd512 && k < 3000) begin step(); k++; end
  endtask

  // Counts edges from the start edge until led rises; a stray start is injected.
  task automatic wait_led();
    int c = 0;
    while (!led && c < 20000) begin
      if (c == 2) start = 1'b1;
      step();
      start = 1'b0;
      c++;
    end
    chk("led_rise_cycle", 32'(c), 32'(exp_d));
  endtask

  // n > 0: stop sampled n edges after REACT entry; n == 0: never press.
  task automatic react_trial(input bit short_wait, input int n);
    int h = 0;
    if (short_wait) idle_short();
    do_start(1'b0);
    wait_led();
    if (n == 0) begin
      while (led && h < 1000) begin step(); h++; end
      chk("led_high_cycles", 32'(h), 32'(T * TO));
      chk_result("timeout", TO, 1'b0, 1'b1);
    end else begin
      repeat (n - 1) step();
      stop = 1'b1; step(); stop = 1'b0;
      if (n > T * TO) chk_result("react_late", TO, 1'b0, 1'b1);
      else            chk_result("react", (n - 1) / T, 1'b0, 1'b0);
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("done_stop_ignored", 32'(done), 1);
  endtask

  // n < 0 means press exactly on the expiring tick.
  task automatic early_trial(input bit with_stop, input int n);
    int m;
    bit seen = 1'b0;
    idle_short();
    do_start(with_stop);
    m = (n < 0) ? exp_d : n;
    repeat (m - 1) begin step(); seen |= led; end
    stop = 1'b1; step(); stop = 1'b0;
    chk("early_led_seen", 32'(seen), 0);
    chk_result("early", 9999, 1'b1, 1'b0);
  endtask

  initial begin
    int r;
    repeat (2) step();
    chk("rst_out", 32'({led, busy, done, early, timeout}), 0);
    chk("rst_ms", 32'(ms_count), 0);

    // release at negedge; start must be taken on the very next edge
    @(negedge clk);
    rst = 1'b0;
    react_trial(1'b0, 149);
    react_trial(1'b1, 0);
    react_trial(1'b1, T * TO);
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(1, T * TO + 10);
      react_trial(1'b1, r);
    end
    early_trial(1'b0, 5 * T);
    early_trial(1'b1, $urandom_range(1, 60));
    early_trial(1'b0, -1);

    // abort mid-REACT
    idle_short();
    do_start(1'b0);
    wait_led();
    r = 0;
    while (ms_count != 14'd12 && r < 200) begin step(); r++; end
    chk("reach_ms12", 32'(ms_count), 12);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'({led, busy, done, early, timeout}), 0);
    chk("async_rst_ms", 32'(ms_count), 0);
    #2 rst = 1'b0;
    do_start(1'b0);
    repeat (6) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk_result("post_rst", 9999, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Parameter TICKS_PER_MS, default 100000, gives clk cycles per 1 ms tick (100 MHz board clock).
REQ-002 Parameter MIN_DELAY_MS, default 2000, is the minimum random wait before led; MIN_DELAY_MS+4095 SHALL be < 8192.
REQ-003 Parameter TIMEOUT_MS, default 1000, is the maximum reaction time; SHALL be ≤ 9998.
REQ-004 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse, already synchronized and debounced: begin a trial.
REQ-007 stop  in  1  single-cycle pulse, already synchronized and debounced: user reaction.
REQ-008 led  out  1  stimulus lamp, high only in REACT.
REQ-009 ms_count  out  14  binary result in ms (0..9999), fed to the binary-to-BCD stage.
REQ-010 busy  out  1  high in WAIT or REACT.
REQ-011 done  out  1  high in DONE.
REQ-012 early  out  1  sticky: stop arrived during WAIT.
REQ-013 timeout  out  1  sticky: TIMEOUT_MS elapsed without stop.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, REACT, DONE; all outputs SHALL be registered.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every clk cycle in every state.
REQ-016 A prescaler SHALL count 0..TICKS_PER_MS-1 and emit a 1-cycle ms_tick at TICKS_PER_MS-1; it SHALL clear on every entry to WAIT and REACT.
REQ-017 IDLE or DONE, start=1: load delay_ms = MIN_DELAY_MS + lfsr[11:0] (13-bit, sampled that cycle); clear ms_count, early, timeout; go to WAIT.
REQ-018 IDLE or DONE, start=1 and stop=1 same cycle: start SHALL win; stop ignored.
REQ-019 WAIT: delay_ms SHALL decrement on each ms_tick; the ms_tick that takes it to 0 SHALL move the FSM to REACT, so led rises exactly delay_ms×TICKS_PER_MS cycles after the start-sampling edge.
REQ-020 WAIT, stop=1: go to DONE, set early=1, ms_count=9999, led stays 0.
REQ-021 WAIT, stop coinciding with the expiring ms_tick: stop SHALL win (early).
REQ-022 REACT entry: led=1, ms_count=0; ms_count SHALL increment by 1 on each ms_tick.
REQ-023 REACT, stop=1: go to DONE, led=0, ms_count frozen at its current value (no increment that cycle even if ms_tick).
REQ-024 REACT, ms_count reaching TIMEOUT_MS: go to DONE the same edge, led=0, timeout=1, ms_count=TIMEOUT_MS.
REQ-025 stop coinciding with the timeout-causing ms_tick: stop SHALL win, ms_count=TIMEOUT_MS-1, timeout=0.
REQ-026 start during WAIT or REACT SHALL be ignored; stop in IDLE or DONE SHALL be ignored.
REQ-027 DONE SHALL hold ms_count, early, timeout until the next accepted start or rst.
REQ-028 ms_count SHALL never exceed 9999; counters SHALL never wrap.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, led=0, ms_count=0, busy=0, done=0, early=0, timeout=0, prescaler=0, delay_ms=0, lfsr=16'hACE1, asynchronously to clk.
REQ-030 rst asserted mid-WAIT or mid-REACT SHALL abort the trial; no partial result retained.
REQ-031 After rst deassertion the block SHALL accept start on the first following clk edge.

Verification (TICKS_PER_MS=4, MIN_DELAY_MS=20, TIMEOUT_MS=50)
REQ-032 Reset: rst pulse -> led=0, ms_count=0, busy=0, done=0, early=0, timeout=0, lfsr=16'hACE1.
REQ-033 Normal trial: start; stop 37 ms (148 cycles) after led rises -> ms_count=37, done=1, led=0, early=0; led rise time matches LFSR reference model ±0 cycles.
REQ-034 Early press: start, stop 5 ms later -> early=1, ms_count=9999, done=1, led never asserted.
REQ-035 Timeout: start, no stop -> led high exactly 200 cycles, ms_count=50, timeout=1, done=1.
REQ-036 Simultaneous: stop on expiring ms_tick in WAIT -> early=1; stop on 50th tick in REACT -> ms_count=49, timeout=0.
REQ-037 rst mid-REACT at ms_count=12 -> all outputs 0 immediately; following start begins a fresh trial.
